fetch_stage: RTL and testbench



---
 rtl/rv32i_pkg.sv | 13 +
 rtl/if_id_reg.sv | 43 ++++
 rtl/fetch_stage.sv | 101 ++++++++++
 tb/tb_fetch_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I constants and fetch FSM state encoding
package rv32i_pkg;

  localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RV_RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_WAIT = 2'd1,
    F_DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with hold and bubble controls
module if_id_reg
  import rv32i_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = RV_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        bubble,
  input  logic        load,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc_plus4_D,
  output logic        valid_D
);

  // A bubble keeps the old PC fields; only the instruction and valid change.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_D    <= NOP_INSTR;
      pc_D       <= 32'd0;
      pc_plus4_D <= 32'd0;
      valid_D    <= 1'b0;
    end else if (bubble) begin
      instr_D <= NOP_INSTR;
      valid_D <= 1'b0;
    end else if (!hold) begin
      if (load) begin
        instr_D    <= instr;
        pc_D       <= pc;
        pc_plus4_D <= pc + 32'd4;
        valid_D    <= 1'b1;
      end else begin
        instr_D <= NOP_INSTR;
        valid_D <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I fetch stage: PC, imem handshake, fetch buffer, IF/ID
module fetch_stage
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RV_RESET_PC,
  parameter logic [31:0] NOP_INSTR = RV_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc_plus4_D,
  output logic        valid_D
);

  fetch_state_t state;
  logic [31:0]  pc_F;
  logic [31:0]  req_pc;
  logic         buf_valid;
  logic [31:0]  buf_instr;
  logic [31:0]  buf_pc;

  logic         grant;
  logic         resp;
  logic         resp_to_buf;
  logic         id_load;
  logic [31:0]  id_instr;
  logic [31:0]  id_pc;
  logic         unused_redirect_lsbs;

  assign imem_req    = (state == F_IDLE) && !buf_valid && !rst;
  assign imem_addr   = pc_F;
  assign grant       = imem_req && imem_gnt;
  assign resp        = (state == F_WAIT) && imem_rvalid;
  assign resp_to_buf = resp && (stall || buf_valid);

  // The buffered instruction is older than any live response, so it goes first.
  assign id_load  = buf_valid || resp;
  assign id_instr = buf_valid ? buf_instr : imem_rdata;
  assign id_pc    = buf_valid ? buf_pc : req_pc;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= F_IDLE;
      pc_F      <= RESET_PC;
      req_pc    <= RESET_PC;
      buf_valid <= 1'b0;
      buf_instr <= NOP_INSTR;
      buf_pc    <= 32'd0;
    end else begin
      if (grant) req_pc <= pc_F;
      if (flush) begin
        pc_F      <= {redirect_pc[31:2], 2'b00};
        buf_valid <= 1'b0;
        // Any response still owed by memory must be swallowed before refetching.
        if (grant || (state != F_IDLE && !imem_rvalid)) state <= F_DROP;
        else state <= F_IDLE;
      end else begin
        if (grant) pc_F <= pc_F + 32'd4;
        if (!stall && buf_valid) buf_valid <= 1'b0;
        if (resp_to_buf) begin
          buf_valid <= 1'b1;
          buf_instr <= imem_rdata;
          buf_pc    <= req_pc;
        end
        case (state)
          F_IDLE:         if (grant) state <= F_WAIT;
          F_WAIT, F_DROP: if (imem_rvalid) state <= F_IDLE;
          default:        state <= F_IDLE;
        endcase
      end
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .hold      (stall),
    .bubble    (flush),
    .load      (id_load),
    .instr     (id_instr),
    .pc        (id_pc),
    .instr_D   (instr_D),
    .pc_D      (pc_D),
    .pc_plus4_D(pc_plus4_D),
    .valid_D   (valid_D)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, flush, imem_gnt, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, valid_D;
  logic [31:0] imem_addr, instr_D, pc_D, pc_plus4_D;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_D    (instr_D),
    .pc_D       (pc_D),
    .pc_plus4_D (pc_plus4_D),
    .valid_D    (valid_D)
  );

  // Program-order reference: PCs fetched but not yet delivered to decode.
  logic [31:0] q[$];
  logic [31:0] mpc = RESET_PC;

  int          stall_mode = 0;
  int          gnt_pct    = 100;
  int          lat_min    = 0;
  int          lat_max    = 0;
  bit          rnd_flush  = 1'b0;
  bit          do_flush   = 1'b0;
  bit          keep_pend  = 1'b0;
  bit          stray_expected = 1'b0;
  logic [31:0] flush_tgt  = 32'd0;

  bit          pend     = 1'b0;
  bit          stale    = 1'b0;
  bit          rv_legal = 1'b0;
  int          cnt      = 0;
  logic [31:0] paddr    = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input bit r);
    @(negedge clk);
    rst = r;
    if (!do_flush && rnd_flush && $urandom_range(0, 19) == 0) begin
      flush     = 1'b1;
      flush_tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom();
    end else begin
      flush = do_flush;
    end
    do_flush    = 1'b0;
    stall       = (stall_mode == 1) || (stall_mode == 2 && $urandom_range(0, 3) == 0);
    redirect_pc = flush ? flush_tgt : $urandom();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom();
    rv_legal    = 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(paddr);
        rv_legal    = !stale;
        stale       = 1'b0;
        pend        = 1'b0;
      end else begin
        cnt--;
      end
    end
    #1;
    imem_gnt = ($urandom_range(0, 99) < gnt_pct);
    if (r) begin
      q.delete();
      mpc = RESET_PC;
      if (keep_pend) stale = pend;
      else pend = 1'b0;
    end else if (flush) begin
      q.delete();
      mpc = {flush_tgt[31:2], 2'b00};
    end
    if (imem_req && imem_gnt) begin
      if (!r && !flush) begin
        check("req_addr", imem_addr, mpc);
        q.push_back(mpc);
        mpc = mpc + 32'd4;
      end
      pend  = 1'b1;
      cnt   = $urandom_range(lat_min, lat_max);
      paddr = imem_addr;
    end
    @(posedge clk);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      step(1'b0);
      #1;
      n++;
    end
    if (!imem_req) begin
      checks++;
      failures++;
      $display("FAIL req_timeout actual=imem_req=0 required=imem_req=1 within 20 cycles");
    end
  endtask

  // Monitor: reset/flush bubbles and in-order delivery against the reference queue.
  always @(posedge clk) begin
    bit          e_rst, e_flush, e_stall;
    logic [31:0] p;
    e_rst   = rst;
    e_flush = flush;
    e_stall = stall;
    assert (!imem_rvalid || rv_legal || stray_expected)
      else $error("imem_rvalid with no request outstanding");
    #1;
    if (e_rst) begin
      check("rst_instr", instr_D, NOP);
      check("rst_pc", pc_D, 32'd0);
      check("rst_pc4", pc_plus4_D, 32'd0);
      check("rst_valid", 32'(valid_D), 32'd0);
    end else if (e_flush) begin
      check("flush_valid", 32'(valid_D), 32'd0);
      check("flush_instr", instr_D, NOP);
    end else if (!e_stall && valid_D) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=pc_D %h required=no instruction", pc_D);
      end else begin
        p = q.pop_front();
        check("sb_pc", pc_D, p);
        check("sb_instr", instr_D, mem_word(p));
        check("sb_pc4", pc_plus4_D, p + 32'd4);
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = 32'd0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    step(1'b1); step(1'b1);
    #1 check("req_in_reset", 32'(imem_req), 32'd0);

    step(1'b0);
    #1 check("lat_t1_valid", 32'(valid_D), 32'd0);
    step(1'b0);
    #1 check("lat_t2_valid", 32'(valid_D), 32'd1);
    check("lat_t2_pc", pc_D, 32'd0);
    step(1'b0); step(1'b0); step(1'b0);
    #1 check("pre_stall_pc", pc_D, 32'd4);

    stall_mode = 1;
    step(1'b0); step(1'b0); step(1'b0);
    #1 check("stall_hold_pc", pc_D, 32'd4);
    check("stall_req", 32'(imem_req), 32'd0);
    stall_mode = 0;
    step(1'b0);
    #1 check("release_pc", pc_D, 32'd8);
    check("release_valid", 32'(valid_D), 32'd1);
    check("release_req", 32'(imem_req), 32'd1);
    check("release_addr", imem_addr, 32'd12);

    lat_min = 1; lat_max = 1;
    step(1'b0);
    lat_min = 0; lat_max = 0;
    do_flush = 1'b1; flush_tgt = 32'h100;
    step(1'b0);
    #1 check("drop_req", 32'(imem_req), 32'd0);
    check("bubble_pc_hold", pc_D, 32'd8);
    step(1'b0);
    #1 check("redir_req", 32'(imem_req), 32'd1);
    check("redir_addr", imem_addr, 32'h100);

    step(1'b0);
    stall_mode = 1;
    step(1'b0);
    #1 check("buf_full_req", 32'(imem_req), 32'd0);
    do_flush = 1'b1; flush_tgt = 32'h200;
    step(1'b0);
    #1 check("fs_valid", 32'(valid_D), 32'd0);
    check("fs_instr", instr_D, NOP);
    check("fs_req", 32'(imem_req), 32'd1);
    check("fs_addr", imem_addr, 32'h200);
    stall_mode = 0;

    do_flush = 1'b1; flush_tgt = 32'hFFFF_FFFE;
    step(1'b0);
    #1 wait_req();
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step(1'b0);
    #1 check("wrap_addr1", imem_addr, 32'd0);

    stall_mode = 1;
    step(1'b0);
    step(1'b1);
    #1 check("rst_buf_req", 32'(imem_req), 32'd0);
    stall_mode = 0;

    lat_min = 2; lat_max = 2;
    step(1'b0);
    keep_pend = 1'b1; gnt_pct = 0; stray_expected = 1'b1;
    step(1'b1);
    keep_pend = 1'b0;
    step(1'b0); step(1'b0);
    #1 check("stray_valid", 32'(valid_D), 32'd0);
    check("stray_req", 32'(imem_req), 32'd1);
    check("stray_addr", imem_addr, RESET_PC);
    step(1'b0);
    stray_expected = 1'b0;
    gnt_pct = 60; lat_min = 0; lat_max = 3; stall_mode = 2; rnd_flush = 1'b1;

    repeat (3000) step($urandom_range(0, 199) == 0);

    stall_mode = 0; rnd_flush = 1'b0; gnt_pct = 0;
    repeat (20) step(1'b0);
    #1 check("drain_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
